// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types, constants and helpers for the BCD-to-binary block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DEF_NUM_DIGITS = 10;
    localparam int         DEF_IDX_W      = $clog2(DEF_NUM_DIGITS);

    function automatic logic bcd_nibble_ok(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

    // Digit-index width; kept at least 1 bit so a single-digit build still elaborates.
    function automatic int bcd_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_bin_seq_if.sv
// ============================================================================
// Module   : bcd_to_bin_seq_if
// Brief    : Handshake, data and run-control bundle for bcd_to_bin_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_to_bin_seq_if #(
    parameter int NUM_DIGITS = 10,
    parameter int BIN_W      = 34,
    parameter int CNT_W      = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] in_bcd;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_W-1:0]        out_bin;
    logic                    out_err;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        conv_count;
    logic                    run_done;

    modport master (
        output in_valid, in_bcd, out_ready, cnt_clr,
        input  in_ready, out_valid, out_bin, out_err, conv_count, run_done
    );

    modport slave (
        input  in_valid, in_bcd, out_ready, cnt_clr,
        output in_ready, out_valid, out_bin, out_err, conv_count, run_done
    );
endinterface

`default_nettype wire

// File: rtl/bcd_to_bin_seq_mac10.sv
// ============================================================================
// Module   : bcd_mac10
// Brief    : Combinational acc*10 + digit; non-BCD nibbles contribute 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 34
) (
    input  wire logic [BIN_W-1:0] i_acc,
    input  wire logic [3:0]       i_nibble,
    output logic      [BIN_W-1:0] o_result,
    output logic                  o_digit_ok
);

    logic [3:0] w_digit;

    always_comb begin
        o_digit_ok = bcd_nibble_ok(i_nibble);
        w_digit    = o_digit_ok ? i_nibble : 4'd0;
        // x10 as x8 + x2 keeps this to two shifts and an adder chain.
        o_result   = (i_acc << 3) + (i_acc << 1) + {{(BIN_W-4){1'b0}}, w_digit};
    end

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module   : bcd_to_bin_seq
// Brief    : Digit-serial packed-BCD to binary converter with run-limit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 10,
    parameter int BIN_W      = 34,
    parameter int MAX_CONV   = 300,
    parameter int CNT_W      = 9
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int                 c_idx_w    = bcd_idx_w(NUM_DIGITS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [CNT_W-1:0]   c_max_cnt  = CNT_W'(MAX_CONV);
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

    bcd_state_e              r_state;
    logic [4*NUM_DIGITS-1:0] r_shift;
    logic [BIN_W-1:0]        r_acc;
    logic                    r_err;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_out_valid;
    logic [BIN_W-1:0]        r_out_bin;
    logic                    r_out_err;
    logic [CNT_W-1:0]        r_count;
    logic                    r_run_done;

    logic [3:0]              w_nibble;
    logic [BIN_W-1:0]        w_acc_next;
    logic                    w_digit_ok;
    logic                    w_in_ready;

    assign w_nibble   = r_shift[4*NUM_DIGITS-1 -: 4];
    assign w_in_ready = (r_state == IDLE) && !r_run_done;

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .i_acc      (r_acc),
        .i_nibble   (w_nibble),
        .o_result   (w_acc_next),
        .o_digit_ok (w_digit_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_err   <= 1'b0;
            r_count     <= '0;
            r_run_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && w_in_ready) begin
                        r_shift <= bus.in_bcd;
                        r_acc   <= '0;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_shift <= r_shift << 4;
                    r_acc   <= w_acc_next;
                    r_err   <= r_err | !w_digit_ok;
                    r_idx   <= r_idx + c_idx_one;
                    if (r_idx == c_last_idx) begin
                        r_out_bin   <= w_acc_next;
                        r_out_err   <= r_err | !w_digit_ok;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                        if (r_count != c_max_cnt) begin
                            r_count    <= r_count + c_cnt_one;
                            r_run_done <= ((r_count + c_cnt_one) == c_max_cnt);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Placed last so a clear coinciding with an output handshake wins.
            if (bus.cnt_clr) begin
                r_count    <= '0;
                r_run_done <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_bin    = r_out_bin;
    assign bus.out_err    = r_out_err;
    assign bus.conv_count = r_count;
    assign bus.run_done   = r_run_done;

endmodule

`default_nettype wire
